pc_sched: RTL

Parametrised program counter with a hardware preemptive scheduler for the multiprogrammed processor. It holds the fetch address and resolves branches relative to the running program's memory partition. It enforces a per-slice instruction quantum and keeps a per-program saved-PC context table. On preemption, trap or program end it returns control to the kernel (program 0). On a kernel `resume` it selects the next ready user program round-robin.

---
 rtl/pc_sched_if.sv | 35 +++
 rtl/pc_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sched_if.sv
// Control/status bundle between the pipeline front end and the PC/scheduler block.
// The master drives branch, flag and scheduling events. The slave returns fetch address and status.
interface pc_sched_if #(
  parameter int AW = 32,
  parameter int PW = 2
);
  logic          stop;
  logic [2:0]    branch_op;
  logic [AW-1:0] target;
  logic [AW-1:0] target_abs;
  logic          zero;
  logic          negative;
  logic          set_quantum;
  logic [AW-1:0] quantum_in;
  logic          trap;
  logic          end_prog;
  logic          resume;
  logic [AW-1:0] pc;
  logic [PW-1:0] cur_prog;
  logic [1:0]    cause;
  logic [AW-1:0] trap_code;
  logic          all_done;

  modport master (
    output stop, branch_op, target, target_abs, zero, negative,
           set_quantum, quantum_in, trap, end_prog, resume,
    input  pc, cur_prog, cause, trap_code, all_done
  );

  modport slave (
    input  stop, branch_op, target, target_abs, zero, negative,
           set_quantum, quantum_in, trap, end_prog, resume,
    output pc, cur_prog, cause, trap_code, all_done
  );
endinterface

// File: rtl/pc_sched.sv
// Program counter with a preemptive round-robin scheduler. It handles partition-relative branches,
// a per-slice quantum and a saved-PC context per user program. Program 0 is the kernel.
module pc_sched #(
  parameter int AW    = 32,
  parameter int NPROG = 3,
  parameter int PART  = 200,
  parameter int PW    = $clog2(NPROG + 1)
) (
  input  logic       clock,
  input  logic       reset,
  pc_sched_if.slave  bus
);
  typedef enum logic {KERNEL, USER} state_t;

  state_t        state_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] quantum_reg;
  logic [AW-1:0] slice_reg;
  logic [AW-1:0] trap_code_reg;
  logic [AW-1:0] pend_code_reg;
  logic [PW-1:0] cur_reg;
  logic [PW-1:0] last_reg;
  logic [1:0]    cause_reg;
  logic          pend_trap_reg;
  logic          pend_end_reg;

  logic [NPROG:1] done_vec;
  logic [AW-1:0]  ctx_vec [1:NPROG];

  logic [AW-1:0] base;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_branch;
  logic          taken;

  always_comb begin
    base   = AW'(cur_reg) * AW'(PART);
    pc_inc = pc_reg + AW'(1);
    taken  = 1'b0;
    case (bus.branch_op)
      3'b001:  taken = 1'b1;
      3'b010:  taken = bus.zero;
      3'b100:  taken = !bus.zero;
      3'b101:  taken = bus.negative;
      3'b110:  taken = bus.negative | bus.zero;
      default: taken = 1'b0;
    endcase
    if (bus.branch_op == 3'b011)
      pc_branch = bus.target_abs;
    else if (taken)
      pc_branch = base + bus.target;
    else
      pc_branch = pc_inc;
  end

  // Widened compare so a slice count at the top of the range cannot wrap into a false "not expired".
  logic [AW:0]   slice_inc_wide;
  logic          q_req;
  logic          end_req;
  logic          trap_req;
  logic          do_switch;
  logic [AW-1:0] ctx_save;

  assign slice_inc_wide = {1'b0, slice_reg} + (AW + 1)'(1);
  assign q_req     = (quantum_reg != '0) && (slice_inc_wide >= {1'b0, quantum_reg});
  assign end_req   = pend_end_reg | bus.end_prog;
  assign trap_req  = pend_trap_reg | bus.trap;
  assign do_switch = !bus.stop && (state_reg == USER) && (bus.branch_op == 3'b000)
                     && (end_req | trap_req | q_req);
  assign ctx_save  = end_req ? pc_reg : pc_inc;

  // Round-robin pick: ids after the last dispatched one first, then wrap around.
  int            cand;
  logic          found;
  logic [PW-1:0] next_id;

  always_comb begin
    cand    = 0;
    found   = 1'b0;
    next_id = '0;
    for (int k = 1; k <= NPROG; k++) begin
      cand = ((int'(last_reg) + k - 1) % NPROG) + 1;
      if (!found && !done_vec[PW'(cand)]) begin
        found   = 1'b1;
        next_id = PW'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= KERNEL;
      pc_reg        <= '0;
      cur_reg       <= '0;
      last_reg      <= '0;
      quantum_reg   <= '0;
      slice_reg     <= '0;
      pend_trap_reg <= 1'b0;
      pend_end_reg  <= 1'b0;
      pend_code_reg <= '0;
      cause_reg     <= 2'd0;
      trap_code_reg <= '0;
    end else begin
      if (bus.set_quantum)
        quantum_reg <= bus.quantum_in;
      if (!bus.stop) begin
        case (state_reg)
          KERNEL: begin
            if (bus.resume && found) begin
              pc_reg    <= ctx_vec[next_id];
              cur_reg   <= next_id;
              last_reg  <= next_id;
              slice_reg <= '0;
              state_reg <= USER;
            end else if (bus.resume) begin
              pc_reg <= pc_inc;
            end else begin
              pc_reg <= pc_branch;
            end
          end
          USER: begin
            if (do_switch) begin
              state_reg     <= KERNEL;
              pc_reg        <= '0;
              cur_reg       <= '0;
              slice_reg     <= '0;
              pend_trap_reg <= 1'b0;
              pend_end_reg  <= 1'b0;
              if (end_req) begin
                cause_reg <= 2'd2;
              end else if (trap_req) begin
                cause_reg     <= 2'd3;
                trap_code_reg <= bus.trap ? bus.target_abs : pend_code_reg;
              end else begin
                cause_reg <= 2'd1;
              end
            end else begin
              pc_reg    <= pc_branch;
              slice_reg <= slice_reg + AW'(1);
              if (bus.trap) begin
                pend_trap_reg <= 1'b1;
                pend_code_reg <= bus.target_abs;
              end
              if (bus.end_prog)
                pend_end_reg <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  for (genvar gi = 1; gi <= NPROG; gi++) begin : g_prog
    logic [AW-1:0] ctx_slot_reg;
    logic          done_bit_reg;

    always_ff @(posedge clock) begin
      if (!reset) begin
        ctx_slot_reg <= AW'(gi * PART);
        done_bit_reg <= 1'b0;
      end else if (do_switch && (cur_reg == PW'(gi))) begin
        ctx_slot_reg <= ctx_save;
        if (end_req)
          done_bit_reg <= 1'b1;
      end
    end

    assign ctx_vec[gi]  = ctx_slot_reg;
    assign done_vec[gi] = done_bit_reg;
  end

  assign bus.pc        = pc_reg;
  assign bus.cur_prog  = cur_reg;
  assign bus.cause     = cause_reg;
  assign bus.trap_code = trap_code_reg;
  assign bus.all_done  = &done_vec;
endmodule
